// File: rtl/zl_uart_host_pkg.sv
// Shared types and constants for the zl_uart host-side serial register master.
package zl_uart_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_GAP   = 3'd2,
        ST_WDATA = 3'd3,
        ST_RWAIT = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6,
        ST_POST  = 3'd7
    } host_state_e;

    localparam int ADDR_BITS      = 8;
    localparam int WRITE_FLAG_BIT = 0;

    localparam logic [6:0] REG_SIG_HI = 7'd0;
    localparam logic [6:0] REG_SIG_LO = 7'd1;
    localparam logic [6:0] REG_REG1   = 7'd2;
    localparam logic [6:0] REG_LED    = 7'd3;

    // Address byte on the wire: register index above the write flag.
    function automatic logic [ADDR_BITS-1:0] make_addr(input logic [6:0] reg_idx, input logic wr);
        return {reg_idx, wr};
    endfunction

endpackage

// File: rtl/zl_uart_host_sync2.sv
// Two-flop synchroniser for the asynchronous serial input; resets to the idle-high level.
module zl_uart_host_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Resolve metastability over two stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/zl_uart_host.sv
// Host-side master: turns parallel register requests into one-bit-per-clock zl_uart frames
// and collects read data returned by the slave.
module zl_uart_host
    import zl_uart_host_pkg::*;
#(
    parameter int WR_GAP     = 2,
    parameter int RD_TIMEOUT = 32,
    parameter int POST_GAP   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       ser_tx,
    input  logic       ser_rx
);

    host_state_e          state_r, state_n;
    logic [3:0]           cnt_r, cnt_n;
    logic [7:0]           gap_r, gap_n;
    logic [ADDR_BITS-1:0] shift_r, shift_n;
    logic [7:0]           wdata_r, wdata_n;
    logic [7:0]           rdata_r, rdata_n;
    logic                 write_r, write_n;
    logic                 tx_r, tx_n;
    logic                 ready_r, ready_n;
    logic                 valid_r, valid_n;
    logic                 timeout_r, timeout_n;
    logic                 rx_s;
    logic                 accept_s;

    zl_uart_host_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ser_rx),
        .q       (rx_s)
    );

    assign accept_s = req_valid & ready_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_POST;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state decode
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE:  if (accept_s) state_n = ST_ADDR; else state_n = ST_IDLE;
            ST_ADDR:  if (cnt_r != 4'd0) state_n = ST_ADDR;
                      else if (write_r) state_n = ST_GAP;
                      else state_n = ST_RWAIT;
            ST_GAP:   if (gap_r == 8'd0) state_n = ST_WDATA; else state_n = ST_GAP;
            ST_WDATA: if (cnt_r == 4'd0) state_n = ST_DONE; else state_n = ST_WDATA;
            ST_RWAIT: if (!rx_s) state_n = ST_RDATA;
                      else if (gap_r == 8'd0) state_n = ST_DONE;
                      else state_n = ST_RWAIT;
            ST_RDATA: if (cnt_r == 4'd1) state_n = ST_DONE; else state_n = ST_RDATA;
            ST_DONE:  state_n = ST_POST;
            ST_POST:  if (gap_r == 8'd0) state_n = ST_IDLE; else state_n = ST_POST;
            default:  state_n = ST_POST;
        endcase
    end

    // Output and datapath decode: values each register takes on the next edge
    always_comb begin
        tx_n      = 1'b1;
        cnt_n     = cnt_r;
        gap_n     = gap_r;
        shift_n   = shift_r;
        wdata_n   = wdata_r;
        write_n   = write_r;
        rdata_n   = rdata_r;
        timeout_n = timeout_r;
        valid_n   = (state_n == ST_DONE);
        ready_n   = (state_n == ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    tx_n    = 1'b0;
                    shift_n = make_addr(req_reg, req_write);
                    write_n = make_addr(req_reg, req_write) >> WRITE_FLAG_BIT;
                    wdata_n = req_wdata;
                    cnt_n   = 4'd8;
                end else begin
                    tx_n = 1'b1;
                end
            end
            ST_ADDR, ST_WDATA: begin
                if (cnt_r != 4'd0) begin
                    tx_n    = shift_r[ADDR_BITS-1];
                    shift_n = {shift_r[ADDR_BITS-2:0], 1'b0};
                    cnt_n   = cnt_r - 4'd1;
                end else if (state_r == ST_WDATA) begin
                    rdata_n   = 8'h00;
                    timeout_n = 1'b0;
                end else if (write_r) begin
                    gap_n = 8'(WR_GAP - 1);
                end else begin
                    gap_n = 8'(RD_TIMEOUT - 1);
                end
            end
            ST_GAP: begin
                if (gap_r == 8'd0) begin
                    tx_n    = 1'b0;
                    shift_n = wdata_r;
                    cnt_n   = 4'd8;
                end else begin
                    gap_n = gap_r - 8'd1;
                end
            end
            ST_RWAIT: begin
                if (!rx_s) begin
                    cnt_n = 4'd8;
                end else if (gap_r == 8'd0) begin
                    rdata_n   = 8'h00;
                    timeout_n = 1'b1;
                end else begin
                    gap_n = gap_r - 8'd1;
                end
            end
            ST_RDATA: begin
                shift_n = {shift_r[ADDR_BITS-2:0], rx_s};
                cnt_n   = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    rdata_n   = {shift_r[ADDR_BITS-2:0], rx_s};
                    timeout_n = 1'b0;
                end else begin
                    rdata_n = rdata_r;
                end
            end
            ST_DONE: gap_n = 8'(POST_GAP - 1);
            ST_POST: if (gap_r != 8'd0) gap_n = gap_r - 8'd1; else gap_n = gap_r;
            default: tx_n = 1'b1;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= 4'd0;
            gap_r     <= 8'(POST_GAP - 1);
            shift_r   <= '0;
            wdata_r   <= 8'h00;
            write_r   <= 1'b0;
            rdata_r   <= 8'h00;
            timeout_r <= 1'b0;
            valid_r   <= 1'b0;
            ready_r   <= 1'b0;
            tx_r      <= 1'b1;
        end else begin
            cnt_r     <= cnt_n;
            gap_r     <= gap_n;
            shift_r   <= shift_n;
            wdata_r   <= wdata_n;
            write_r   <= write_n;
            rdata_r   <= rdata_n;
            timeout_r <= timeout_n;
            valid_r   <= valid_n;
            ready_r   <= ready_n;
            tx_r      <= tx_n;
        end
    end

    assign req_ready   = ready_r;
    assign rsp_valid   = valid_r;
    assign rsp_rdata   = rdata_r;
    assign rsp_timeout = timeout_r;
    assign ser_tx      = tx_r;

endmodule

// File: tb/tb_zl_uart_host.sv
// Bench for zl_uart_host: a behavioural zl_uart slave on the serial pins plus a register-map
// reference model that predicts every response.
module tb_zl_uart_host;
    import zl_uart_host_pkg::*;

    localparam int WR_GAP     = 2;
    localparam int RD_TIMEOUT = 32;
    localparam int POST_GAP   = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_write;
    logic [6:0] req_reg;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_timeout, ser_tx, ser_rx;
    logic [7:0] rsp_rdata;

    logic       rx_en = 1'b1;
    logic       rx_glitch = 1'b0;
    logic       slv_tx = 1'b1;
    logic [7:0] slv_regs [0:3];
    logic [7:0] slv_addr = 8'hFF;
    logic [6:0] led_out;
    logic [7:0] ref_regs [0:3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ser_rx  = (rx_en ? slv_tx : 1'b1) & ~rx_glitch;
    assign led_out = slv_regs[3][6:0];

    zl_uart_host #(.WR_GAP(WR_GAP), .RD_TIMEOUT(RD_TIMEOUT), .POST_GAP(POST_GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .ser_tx(ser_tx), .ser_rx(ser_rx)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural zl_uart slave ----------------
    task automatic slv_step(output bit ok);
        @(negedge clk);
        ok = reset_n;
    endtask

    task automatic slv_frame();
        bit ok;
        logic [7:0] a = 8'h00;
        logic [7:0] d = 8'h00;
        int n = 0;
        do begin slv_step(ok); if (!ok) return; end while (ser_tx !== 1'b0);
        for (int i = 0; i < 8; i++) begin
            slv_step(ok); if (!ok) return;
            a = {a[6:0], ser_tx};
        end
        slv_addr = a;
        if (a[0]) begin
            slv_step(ok); if (!ok) return;
            do begin slv_step(ok); if (!ok) return; n++; end while (ser_tx !== 1'b0 && n < 64);
            if (n >= 64) return;
            for (int i = 0; i < 8; i++) begin
                slv_step(ok); if (!ok) return;
                d = {d[6:0], ser_tx};
            end
            if (a[7:1] == REG_REG1 || a[7:1] == REG_LED) slv_regs[a[2:1]] = d;
        end else begin
            d = (a[7:3] == 5'd0) ? slv_regs[a[2:1]] : 8'h00;
            repeat (2) begin slv_step(ok); if (!ok) return; end
            slv_tx = 1'b0;
            for (int i = 0; i < 8; i++) begin
                slv_step(ok); if (!ok) return;
                slv_tx = d[7-i];
            end
            slv_step(ok);
        end
    endtask

    initial begin
        slv_regs[0] = 8'hDE; slv_regs[1] = 8'hDA; slv_regs[2] = 8'h00; slv_regs[3] = 8'h00;
        forever begin
            slv_frame();
            slv_tx = 1'b1;
            if (!reset_n) @(posedge reset_n);
        end
    end

    // ---------------- reference register map ----------------
    function automatic logic [7:0] ref_read(input logic [6:0] r);
        return (r < 7'd4) ? ref_regs[r[1:0]] : 8'h00;
    endfunction

    // Issue one request and watch it through to req_ready again; ends on a negedge.
    task automatic run_txn(input bit wr, input logic [6:0] r, input logic [7:0] wd, input bit keep,
                           output logic [7:0] rd, output bit to, output int lat);
        int n = 0;
        bit busy_ready = 1'b0;
        bit hold_bad = 1'b0;
        rd = 8'h00; to = 1'b0; lat = 0;
        req_write = wr; req_reg = r; req_wdata = wd; req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk_eq("accept wait", 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            if (req_ready) busy_ready = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk_eq("rsp wait", rsp_valid, 1'b1);
        chk_eq("ready during frame", busy_ready, 1'b0);
        rd = rsp_rdata; to = rsp_timeout;
        @(negedge clk);
        chk_eq("rsp pulse", rsp_valid, 1'b0);
        n = 1;
        while (!req_ready && n < 50) begin
            if (rsp_rdata !== rd || rsp_timeout !== to) hold_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk_eq("post gap", n, POST_GAP + 1);
        chk_eq("rsp hold", hold_bad, 1'b0);
    endtask

    task automatic do_txn(input string tag, input bit wr, input logic [6:0] r, input logic [7:0] wd,
                          input bit keep, input bit expect_to);
        logic [7:0] rd;
        logic [7:0] exp_rd;
        bit to;
        int lat;
        exp_rd = (wr || expect_to) ? 8'h00 : ref_read(r);
        run_txn(wr, r, wd, keep, rd, to, lat);
        chk_eq({tag, " rdata"}, rd, exp_rd);
        chk_eq({tag, " timeout"}, to, expect_to);
        chk_eq({tag, " addr"}, slv_addr, {r, wr});
        if (wr) begin
            chk_eq({tag, " latency"}, lat, 9 + WR_GAP + 9 + 1);
            if (r == REG_REG1 || r == REG_LED) ref_regs[r[1:0]] = wd;
        end else if (expect_to) begin
            chk_eq({tag, " latency"}, lat, 9 + RD_TIMEOUT + 1);
        end
    endtask

    initial begin
        int n;
        int vcount;
        logic [6:0] r;
        bit wr;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_reg = 7'd0; req_wdata = 8'h00;
        ref_regs[0] = 8'hDE; ref_regs[1] = 8'hDA; ref_regs[2] = 8'h00; ref_regs[3] = 8'h00;
        repeat (3) @(negedge clk);
        chk_eq("reset ser_tx", ser_tx, 1'b1);
        chk_eq("reset req_ready", req_ready, 1'b0);
        chk_eq("reset rsp_valid", rsp_valid, 1'b0);
        chk_eq("reset rsp_rdata", rsp_rdata, 8'h00);
        chk_eq("reset rsp_timeout", rsp_timeout, 1'b0);
        reset_n = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk_eq("reset post gap", n, POST_GAP);

        do_txn("rd sig_hi", 1'b0, REG_SIG_HI, 8'h00, 1'b0, 1'b0);
        do_txn("rd sig_lo", 1'b0, REG_SIG_LO, 8'h00, 1'b0, 1'b0);
        do_txn("wr reg1", 1'b1, REG_REG1, 8'h5A, 1'b0, 1'b0);
        do_txn("rd reg1", 1'b0, REG_REG1, 8'h00, 1'b0, 1'b0);
        do_txn("wr led", 1'b1, REG_LED, 8'h2A, 1'b0, 1'b0);
        chk_eq("led_out", led_out, 7'h2A);
        do_txn("rd led", 1'b0, REG_LED, 8'h00, 1'b0, 1'b0);

        rx_en = 1'b0;
        do_txn("rd timeout", 1'b0, REG_SIG_HI, 8'h00, 1'b0, 1'b1);
        rx_en = 1'b1;

        do_txn("held r0", 1'b0, REG_SIG_HI, 8'h00, 1'b1, 1'b0);
        do_txn("held w2", 1'b1, REG_REG1, 8'h11, 1'b1, 1'b0);
        do_txn("held r2", 1'b0, REG_REG1, 8'h00, 1'b1, 1'b0);
        req_valid = 1'b0;

        // A glitch on the serial input while idle must not start anything
        rx_glitch = 1'b1;
        @(negedge clk);
        rx_glitch = 1'b0;
        vcount = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid || !req_ready) vcount++; end
        chk_eq("idle glitch", vcount, 0);
        do_txn("rd after glitch", 1'b0, REG_SIG_LO, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of an all-zero address frame
        req_write = 1'b0; req_reg = REG_SIG_HI; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("pre-reset ser_tx", ser_tx, 1'b0);
        #1 reset_n = 1'b0;
        #1 chk_eq("async reset ser_tx", ser_tx, 1'b1);
        vcount = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid) vcount++; end
        reset_n = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); if (rsp_valid) vcount++; n++; end
        chk_eq("mid-frame reset post gap", n, POST_GAP);
        chk_eq("mid-frame reset no rsp", vcount, 0);
        do_txn("rd sig_lo after reset", 1'b0, REG_SIG_LO, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0) ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
            do_txn("random", wr, r, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        end
        chk_eq("final led_out", led_out, ref_regs[3][6:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
